// File: rtl/proc_pkg.sv
// Shared processor constants: opcodes, ALU ops, status codes and the multdiv sequencer state type.
package proc_pkg;

    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned ALUOP_W    = 5;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CTR_W      = 7;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_J     = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_BLT   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SW    = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_LW    = 5'b01000;

    localparam logic [ALUOP_W-1:0] ALU_MUL = 5'b00110;
    localparam logic [ALUOP_W-1:0] ALU_DIV = 5'b00111;

    localparam logic [DATA_W-1:0] STAT_MUL_EXC = 32'd4;
    localparam logic [DATA_W-1:0] STAT_DIV_EXC = 32'd5;

    localparam logic [REG_ADDR_W-1:0] REG_RSTATUS = 5'd30;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_WAIT = 2'd1,
        MD_WB   = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_timeout_ctr.sv
// Counts WAIT cycles of a multdiv operation; flags the last permitted cycle.
module md_timeout_ctr
    import proc_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic term_c_o
);

    logic [CTR_W-1:0] cnt_q;
    logic [CTR_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CTR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal when the current WAIT cycle is the last one allowed.
    assign term_c_o = (cnt_q == CTR_W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequences a multi-cycle mul/div: start strobe, PC stall, then one register-file writeback.
module multdiv_seq_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [ALUOP_W-1:0]    alu_op,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  md_result_rdy,
    input  logic                  md_exception,
    output logic                  ctrl_mult,
    output logic                  ctrl_div,
    output logic                  stall,
    output logic                  md_we,
    output logic [REG_ADDR_W-1:0] md_waddr,
    output logic                  md_wsel,
    output logic [DATA_W-1:0]     md_status
);

    md_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  kind_q, kind_d;   // 0 mul, 1 div
    logic                  exc_q, exc_d;

    logic is_mul, is_div, is_md;
    logic ctr_clr, ctr_en, ctr_term;

    assign is_mul = (opcode == OP_RTYPE) && (alu_op == ALU_MUL);
    assign is_div = (opcode == OP_RTYPE) && (alu_op == ALU_DIV);
    assign is_md  = is_mul || is_div;

    md_timeout_ctr #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (ctr_clr),
        .en_i     (ctr_en),
        .term_c_o (ctr_term)
    );

    // Next-state and output decode; detect strobes are Mealy and masked while reset is held.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        kind_d    = kind_q;
        exc_d     = exc_q;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        stall     = 1'b0;
        md_we     = 1'b0;
        md_waddr  = '0;
        md_wsel   = 1'b0;
        md_status = '0;

        case (state_q)
            MD_IDLE: begin
                if (is_md && reset) begin
                    ctrl_mult = is_mul;
                    ctrl_div  = is_div;
                    stall     = 1'b1;
                    rd_d      = rd;
                    kind_d    = is_div;
                    exc_d     = 1'b0;
                    ctr_clr   = 1'b1;
                    state_d   = MD_WAIT;
                end
            end
            MD_WAIT: begin
                stall  = 1'b1;
                ctr_en = 1'b1;
                if (md_result_rdy) begin
                    exc_d   = md_exception;
                    state_d = MD_WB;
                end else if (ctr_term) begin
                    exc_d   = 1'b1;
                    state_d = MD_WB;
                end
            end
            MD_WB: begin
                md_we     = 1'b1;
                md_waddr  = exc_q ? REG_RSTATUS : rd_q;
                md_wsel   = exc_q;
                md_status = exc_q ? (kind_q ? STAT_DIV_EXC : STAT_MUL_EXC) : '0;
                state_d   = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // State and captured-instruction registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            rd_q    <= '0;
            kind_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            kind_q  <= kind_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Directed bench for multdiv_seq_ctrl with hand-computed per-cycle expectations.
module tb_multdiv_seq_ctrl;
    import proc_pkg::*;

    localparam int unsigned TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [4:0]  rd;
    logic        md_result_rdy;
    logic        md_exception;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        md_we;
    logic [4:0]  md_waddr;
    logic        md_wsel;
    logic [31:0] md_status;

    int n_checks = 0;
    int n_errors = 0;

    multdiv_seq_ctrl #(
        .MD_TIMEOUT (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .alu_op        (alu_op),
        .rd            (rd),
        .md_result_rdy (md_result_rdy),
        .md_exception  (md_exception),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .stall         (stall),
        .md_we         (md_we),
        .md_waddr      (md_waddr),
        .md_wsel       (md_wsel),
        .md_status     (md_status)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic m, input logic d, input logic s,
                              input logic we, input logic [4:0] wa, input logic ws,
                              input logic [31:0] st);
        chk_eq({tag, ".mult"},   32'(ctrl_mult), 32'(m));
        chk_eq({tag, ".div"},    32'(ctrl_div),  32'(d));
        chk_eq({tag, ".stall"},  32'(stall),     32'(s));
        chk_eq({tag, ".we"},     32'(md_we),     32'(we));
        chk_eq({tag, ".waddr"},  32'(md_waddr),  32'(wa));
        chk_eq({tag, ".wsel"},   32'(md_wsel),   32'(ws));
        chk_eq({tag, ".status"}, md_status,      st);
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] r,
                         input logic rdy, input logic exc);
        opcode        = op;
        alu_op        = aop;
        rd            = r;
        md_result_rdy = rdy;
        md_exception  = exc;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset held with a mul in decode: everything must stay quiet.
        reset = 1'b0;
        drive(OP_RTYPE, ALU_MUL, 5'd7, 1'b0, 1'b0);
        #2;
        expect_out("reset", 0, 0, 0, 0, 5'd0, 0, 32'd0);
        step();
        drive(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        settle();
        expect_out("idle0", 0, 0, 0, 0, 5'd0, 0, 32'd0);

        // mul rd=7, ready in 3rd WAIT cycle; rd changes during WAIT to prove capture.
        step(); drive(OP_RTYPE, ALU_MUL, 5'd7, 1'b0, 1'b0); settle();
        expect_out("t1.T0", 1, 0, 1, 0, 5'd0, 0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(); drive(OP_RTYPE, ALU_MUL, 5'd3, logic'(k == 3), 1'b0); settle();
            expect_out($sformatf("t1.T%0d", k), 0, 0, 1, 0, 5'd0, 0, 32'd0);
        end
        step(); drive(OP_RTYPE, ALU_MUL, 5'd3, 1'b0, 1'b0); settle();
        expect_out("t1.wb", 0, 0, 0, 1, 5'd7, 0, 32'd0);
        step(); drive(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        expect_out("t1.idle", 0, 0, 0, 0, 5'd0, 0, 32'd0);

        // div rd=9: lone exception ignored, then ready with exception.
        step(); drive(OP_RTYPE, ALU_DIV, 5'd9, 1'b0, 1'b0); settle();
        expect_out("t2.T0", 0, 1, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_DIV, 5'd9, 1'b0, 1'b1); settle();
        expect_out("t2.T1", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_DIV, 5'd9, 1'b1, 1'b1); settle();
        expect_out("t2.T2", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_DIV, 5'd9, 1'b0, 1'b0); settle();
        expect_out("t2.wb", 0, 0, 0, 1, 5'd30, 1, 32'd5);
        step(); drive(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        expect_out("t2.idle", 0, 0, 0, 0, 5'd0, 0, 32'd0);

        // mul rd=11, never ready: WB at T(TO+1) with mul exception status.
        step(); drive(OP_RTYPE, ALU_MUL, 5'd11, 1'b0, 1'b0); settle();
        expect_out("t3.T0", 1, 0, 1, 0, 5'd0, 0, 32'd0);
        for (int k = 1; k <= int'(TO); k++) begin
            step(); settle();
            expect_out($sformatf("t3.T%0d", k), 0, 0, 1, 0, 5'd0, 0, 32'd0);
        end
        step(); settle();
        expect_out("t3.wb", 0, 0, 0, 1, 5'd30, 1, 32'd4);
        step(); drive(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        expect_out("t3.idle", 0, 0, 0, 0, 5'd0, 0, 32'd0);

        // mul rd=12, ready exactly on the timeout cycle: ready wins.
        step(); drive(OP_RTYPE, ALU_MUL, 5'd12, 1'b0, 1'b0); settle();
        expect_out("t4.T0", 1, 0, 1, 0, 5'd0, 0, 32'd0);
        for (int k = 1; k <= int'(TO); k++) begin
            step(); drive(OP_RTYPE, ALU_MUL, 5'd12, logic'(k == int'(TO)), 1'b0); settle();
            expect_out($sformatf("t4.T%0d", k), 0, 0, 1, 0, 5'd0, 0, 32'd0);
        end
        step(); settle();
        expect_out("t4.wb", 0, 0, 0, 1, 5'd12, 0, 32'd0);
        step(); drive(OP_ADDI, 5'd0, 5'd0, 1'b1, 1'b1); settle();
        expect_out("t4.rdy_idle", 0, 0, 0, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        expect_out("t4.idle", 0, 0, 0, 0, 5'd0, 0, 32'd0);

        // Reset in the 2nd WAIT cycle, then a fresh mul after release.
        step(); drive(OP_RTYPE, ALU_MUL, 5'd5, 1'b0, 1'b0); settle();
        expect_out("t5.T0", 1, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); settle();
        expect_out("t5.T1", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); settle();
        expect_out("t5.T2", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        #1 reset = 1'b0;
        #1;
        expect_out("t5.rst_async", 0, 0, 0, 0, 5'd0, 0, 32'd0);
        step(); settle();
        expect_out("t5.rst_held", 0, 0, 0, 0, 5'd0, 0, 32'd0);
        reset = 1'b1;
        settle();
        expect_out("t5.redetect", 1, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_MUL, 5'd5, 1'b1, 1'b0); settle();
        expect_out("t5.T1b", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_MUL, 5'd5, 1'b0, 1'b0); settle();
        expect_out("t5.wb", 0, 0, 0, 1, 5'd5, 0, 32'd0);

        // Back-to-back mul rd=4 then div rd=6 with no dead cycle.
        step(); drive(OP_RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0); settle();
        expect_out("t6.mul.T0", 1, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_MUL, 5'd4, 1'b1, 1'b0); settle();
        expect_out("t6.mul.T1", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_MUL, 5'd4, 1'b0, 1'b0); settle();
        expect_out("t6.mul.wb", 0, 0, 0, 1, 5'd4, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_DIV, 5'd6, 1'b0, 1'b0); settle();
        expect_out("t6.div.T0", 0, 1, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_DIV, 5'd6, 1'b1, 1'b0); settle();
        expect_out("t6.div.T1", 0, 0, 1, 0, 5'd0, 0, 32'd0);
        step(); drive(OP_RTYPE, ALU_DIV, 5'd6, 1'b0, 1'b0); settle();
        expect_out("t6.div.wb", 0, 0, 0, 1, 5'd6, 0, 32'd0);
        step(); drive(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        expect_out("t6.idle", 0, 0, 0, 0, 5'd0, 0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
